// File: rtl/frame_pkg.sv
// Shared frame constants and arbiter FSM states.
// Also used by the mixer; keep ID values in sync with framing tools.
package frame_pkg;

  localparam int ID_WIDTH = 16;

  localparam logic [ID_WIDTH-1:0] HEADER_ID       = 16'hAAAA;
  localparam logic [ID_WIDTH-1:0] FOOTER_ID       = 16'h5555;
  localparam logic [ID_WIDTH-1:0] ERROR_HEADER_ID = 16'hAAEE;
  localparam logic [ID_WIDTH-1:0] ERROR_FOOTER_ID = 16'h55EE;

  localparam logic [63:0] IDLE_WORD = 64'h0000_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    SYNC
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester selection starting at ptr.
// Pure combinational; one-hot grant plus any-request flag.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [PW-1:0] k;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (!valid && req[k]) begin
        grant[k] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin merge of N FWFT FIFOs onto one stream.
// Repairs lost headers/footers with error words and resyncs.
module frame_rr_arbiter
  import frame_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [N_CH*DATA_WIDTH-1:0]  DIN,
  input  logic [N_CH-1:0]             CH_EMPTY,
  input  logic [N_CH-1:0]             READ_REQUEST,
  output logic [N_CH-1:0]             RE,
  input  logic                        iREADY,
  output logic [DATA_WIDTH-1:0]       DOUT,
  output logic                        oVALID,
  output logic [N_CH-1:0]             GRANT,
  output logic                        ERR_HEADER_LOST,
  output logic                        ERR_FOOTER_LOST
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LW = DATA_WIDTH - ID_WIDTH;

  localparam logic [PW-1:0] LAST = PW'(N_CH - 1);

  localparam logic [DATA_WIDTH-1:0] IDLE_W =
    {IDLE_WORD[63 -: ID_WIDTH], {LW{1'b1}}};
  localparam logic [DATA_WIDTH-1:0] HDR_ERR_W =
    {ERROR_HEADER_ID, {LW{1'b1}}};
  localparam logic [DATA_WIDTH-1:0] FTR_ERR_W =
    {{LW{1'b1}}, ERROR_FOOTER_ID};

  state_t state;

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         gidx;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         nxt_ptr;
  logic [N_CH-1:0]       pick;
  logic                  pick_valid;
  logic                  first;
  logic [DATA_WIDTH-1:0] word;
  logic                  cur_empty;
  logic                  slot_free;
  logic                  hdr_hit;
  logic                  ftr_hit;
  logic                  ftr_lost;
  logic                  pop;

  rr_picker #(
    .N  (N_CH),
    .PW (PW)
  ) u_pick (
    .req   (READ_REQUEST),
    .ptr   (rr_ptr),
    .grant (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (pick[k]) pick_idx = PW'(k);
    end
  end

  always_comb begin
    word      = '0;
    cur_empty = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (gidx == PW'(k)) begin
        word      = DIN[k*DATA_WIDTH +: DATA_WIDTH];
        cur_empty = CH_EMPTY[k];
      end
    end
  end

  assign slot_free = !oVALID || iREADY;
  assign hdr_hit   = word[DATA_WIDTH-1 -: ID_WIDTH] == HEADER_ID;
  assign ftr_hit   = word[ID_WIDTH-1:0] == FOOTER_ID;
  assign nxt_ptr   = (gidx == LAST) ? '0 : gidx + 1'b1;

  // A header mid-frame stays in the FIFO to open the next frame.
  assign ftr_lost = (state == STREAM) && slot_free && !cur_empty
                  && !first && hdr_hit;

  assign pop = ((state == STREAM) && slot_free && !cur_empty && !ftr_lost)
             || ((state == SYNC) && !cur_empty);

  always_comb begin
    RE = '0;
    for (int k = 0; k < N_CH; k++) begin
      RE[k] = pop && (gidx == PW'(k));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      gidx            <= '0;
      first           <= 1'b0;
      GRANT           <= '0;
      DOUT            <= IDLE_W;
      oVALID          <= 1'b0;
      ERR_HEADER_LOST <= 1'b0;
      ERR_FOOTER_LOST <= 1'b0;
    end else begin
      ERR_HEADER_LOST <= 1'b0;
      ERR_FOOTER_LOST <= 1'b0;
      if (slot_free) oVALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= STREAM;
            GRANT <= pick;
            gidx  <= pick_idx;
            first <= 1'b1;
          end
        end
        STREAM: begin
          if (ftr_lost) begin
            DOUT            <= FTR_ERR_W;
            oVALID          <= 1'b1;
            ERR_FOOTER_LOST <= 1'b1;
            state           <= IDLE;
            GRANT           <= '0;
            rr_ptr          <= nxt_ptr;
          end else if (pop) begin
            first  <= 1'b0;
            oVALID <= 1'b1;
            if (first && !hdr_hit) begin
              DOUT            <= HDR_ERR_W;
              ERR_HEADER_LOST <= 1'b1;
              if (ftr_hit) begin
                state  <= IDLE;
                GRANT  <= '0;
                rr_ptr <= nxt_ptr;
              end else begin
                state <= SYNC;
              end
            end else begin
              DOUT <= word;
              if (ftr_hit) begin
                state  <= IDLE;
                GRANT  <= '0;
                rr_ptr <= nxt_ptr;
              end
            end
          end
        end
        SYNC: begin
          if (pop && ftr_hit) begin
            state  <= IDLE;
            GRANT  <= '0;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_rr_arbiter.md
FRAME_RR_ARBITER -- requirements
Module: frame_rr_arbiter

Interface
REQ-001 Parameter: N_CH, 4, number of input channels (2..8).
REQ-002 Parameter: DATA_WIDTH, 64, word width; ID fields are the top 16 bits (header) and low 16 bits (footer).
REQ-003 Port: CLK  in  1  clock; all logic on rising edge.
REQ-004 Port: RESET  in  1  reset; synchronous, active-high.
REQ-005 Port: DIN  in  N_CH*DATA_WIDTH  per-channel first-word-fall-through FIFO head word; channel k occupies slice k.
REQ-006 Port: CH_EMPTY  in  N_CH  per-channel FIFO empty flag.
REQ-007 Port: READ_REQUEST  in  N_CH  per-channel flag: FIFO holds at least one complete frame.
REQ-008 Port: RE  out  N_CH  per-channel FIFO pop; at most one bit set.
REQ-009 Port: iREADY  in  1  downstream ready.
REQ-010 Port: DOUT  out  DATA_WIDTH  registered output word.
REQ-011 Port: oVALID  out  1  DOUT valid; a transfer occurs when oVALID & iREADY.
REQ-012 Port: GRANT  out  N_CH  one-hot owner of the output; zero when idle.
REQ-013 Port: ERR_HEADER_LOST / ERR_FOOTER_LOST  out  1 each  single-cycle error pulses.

Function
REQ-014 Constants: HEADER_ID 0xAAAA, FOOTER_ID 0x5555, ERROR_HEADER_ID 0xAAEE, ERROR_FOOTER_ID 0x55EE, IDLE_WORD = {0x0000, all ones}.
REQ-015 FSM states: IDLE, STREAM, SYNC; only these three are used.
REQ-016 IDLE: if any READ_REQUEST is set, grant the first requester at or after rr_ptr (modulo N_CH) and go to STREAM the next cycle with GRANT set; otherwise stay in IDLE.
REQ-017 Output register: may load when !oVALID | iREADY ("slot free").
REQ-018 In STREAM, RE[g] = slot free & !CH_EMPTY[g]; the popped word loads into DOUT with oVALID=1 on the following edge.
REQ-019 If the slot is free and no pop occurs, oVALID deasserts; DOUT holds.
REQ-020 STREAM, first word of a frame: if its top 16 bits != HEADER_ID, the block pops it, loads ERROR_HEADER_ID followed by all ones, pulses ERR_HEADER_LOST and goes to SYNC.
REQ-021 STREAM, footer: a popped word whose low 16 bits == FOOTER_ID ends the frame; state returns to IDLE, GRANT clears, and rr_ptr becomes g+1 (wrapping N_CH-1 to 0).
REQ-022 STREAM, non-first word carrying HEADER_ID (footer lost): the block does not pop it, loads all ones followed by ERROR_FOOTER_ID, pulses ERR_FOOTER_LOST, then goes to IDLE and advances rr_ptr; the header word stays in the FIFO for the next grant.
REQ-023 SYNC: pop the granted channel without output until a footer has been popped (consumed), then go to IDLE and advance rr_ptr.
REQ-024 READ_REQUEST changes while not in IDLE are ignored; no preemption mid-frame.
REQ-025 CH_EMPTY mid-frame stalls without ending the frame.
REQ-026 Simultaneous footer pop and a new READ_REQUEST: the new grant happens in IDLE next cycle, giving one idle cycle between frames.
REQ-027 Latency: a request is seen at edge t; GRANT is set at t+1; RE is first asserted at t+1; the first DOUT is valid at t+2.

Reset
REQ-028 On RESET, state becomes IDLE, rr_ptr becomes 0, RE/GRANT/oVALID/error pulses become 0, and DOUT becomes IDLE_WORD.
REQ-029 RESET mid-frame abandons the frame without emitting a footer; the partial frame left in the FIFO is resynchronised by REQ-020.

Structure
REQ-030 The shared package frame_pkg holds the ID constants, IDLE_WORD, ID_WIDTH=16 and the FSM state enum; the existing mixer uses the same package.
REQ-031 The combinational sub-module rr_picker (inputs: req, ptr; outputs: one-hot grant, valid) performs the round-robin selection.

Verification
REQ-032 Channels 0 and 2 request together with rr_ptr=0 -> ch0 frame (AAAA..., data, ...5555) is streamed first, then ch2 after one idle cycle; rr_ptr=3 afterwards.
REQ-033 iREADY toggles 1,0,1,0 during a 4-word frame -> all four words appear in order with no loss or duplication; RE is never asserted while oVALID & !iREADY.
REQ-034 Ch1 frame whose first word is 0x1234... -> output word 0xAAEE_FFFF_FFFF_FFFF, ERR_HEADER_LOST pulses once, words up to the footer are popped silently, then the block returns to IDLE.
REQ-035 Ch3 frame with a second header before any footer -> output 0xFFFF_FFFF_FFFF_55EE, ERR_FOOTER_LOST pulses, RE[3] stays low for the header word, and that header starts the next ch3 frame.
REQ-036 RESET asserted on the 3rd word of a frame -> the next cycle shows oVALID=0, DOUT=0x0000_FFFF_FFFF_FFFF, GRANT=0, rr_ptr=0.
REQ-037 All channels request continuously for 2*N_CH frames -> grants rotate 0,1,2,3,0,1,2,3.
